hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/muldiv_timer.sv | 30 +++
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   md_state_t  : mult/div sequencer states
//   *_DEFAULT   : default multiply/divide stall lengths (total stalled cycles)
//   REG_ZERO    : architectural zero register number (never a real hazard source)
//   timer_load  : counter preload for an operation of n total stall cycles
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    localparam int unsigned MUL_CYCLES_DEFAULT = 4;
    localparam int unsigned DIV_CYCLES_DEFAULT = 32;
    localparam logic [4:0]  REG_ZERO           = 5'd0;

    // The IDLE start cycle stalls once and BUSY stalls for count+1 cycles
    // (count down to and including 0), so N total needs a preload of N-2.
    function automatic logic [7:0] timer_load(input int unsigned n);
        return 8'(n - 2);
    endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Down-counter timing a multi-cycle multiply/divide.
//   Clk, Rst_n  : clock, async active-low reset (count cleared)
//   i_load      : load i_load_val this edge (takes priority over i_dec)
//   i_load_val  : preload value
//   i_dec       : decrement this edge
//   o_zero      : count is zero
module muldiv_timer (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller.
//   Inputs : ID operand regs (IDRs/IDRt/IDUsesRt), EX load info
//            (EXMemRead/EXDestReg), mult/div start (MulDivStart/MulDivIsDiv),
//            taken branch in ID (BranchTaken).
//   Outputs: PC / IF-ID / ID-EX enables, bubble and flush controls
//            (combinational), HiLoWrite strobe and MulDivBusy (registered),
//            StallCount saturating count of PC-stalled cycles.
// Priority: mult/div stall > load-use stall > taken-branch flush.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUsesRt,
    input  logic        EXMemRead,
    input  logic [4:0]  EXDestReg,
    input  logic        MulDivStart,
    input  logic        MulDivIsDiv,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXWrite,
    output logic        IDEXBubble,
    output logic        EXMEMBubble,
    output logic        HiLoWrite,
    output logic        MulDivBusy,
    output logic [15:0] StallCount
);

    md_state_t   r_state;
    logic        r_hilo;
    logic        r_busy;
    logic [15:0] r_stall_cnt;

    logic        w_timer_load;
    logic        w_timer_dec;
    logic        w_timer_zero;
    logic [7:0]  w_load_val;
    logic        w_md_stall;
    logic        w_load_use;

    assign w_load_val   = MulDivIsDiv ? timer_load(DIV_CYCLES) : timer_load(MUL_CYCLES);
    assign w_timer_load = (r_state == ST_IDLE) && MulDivStart;
    assign w_timer_dec  = (r_state == ST_BUSY) && !w_timer_zero;
    // Start is honoured only in IDLE, so DONE never restarts the sequencer.
    assign w_md_stall   = w_timer_load || (r_state == ST_BUSY);

    assign w_load_use = EXMemRead && (EXDestReg != REG_ZERO) &&
                        ((EXDestReg == IDRs) || (IDUsesRt && (EXDestReg == IDRt)));

    muldiv_timer u_timer (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .i_load     (w_timer_load),
        .i_load_val (w_load_val),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    // Sequencer with registered HiLoWrite / MulDivBusy.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_hilo  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hilo <= 1'b0;
                    if (MulDivStart) begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_timer_zero) begin
                        r_state <= ST_DONE;
                        r_hilo  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_hilo  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hilo  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        IFIDFlush   = 1'b0;
        if (w_md_stall) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
        end else if (w_load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign HiLoWrite  = r_hilo;
    assign MulDivBusy = r_busy;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int MUL = 4;
    localparam int DIV = 32;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [4:0]  IDRs = '0, IDRt = '0, EXDestReg = '0;
    logic        IDUsesRt = 1'b0, EXMemRead = 1'b0;
    logic        MulDivStart = 1'b0, MulDivIsDiv = 1'b0, BranchTaken = 1'b0;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble;
    logic        HiLoWrite, MulDivBusy;
    logic [15:0] StallCount;

    hazard_stall_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .EXMemRead(EXMemRead), .EXDestReg(EXDestReg), .MulDivStart(MulDivStart),
        .MulDivIsDiv(MulDivIsDiv), .BranchTaken(BranchTaken), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXWrite(IDEXWrite),
        .IDEXBubble(IDEXBubble), .EXMEMBubble(EXMEMBubble), .HiLoWrite(HiLoWrite),
        .MulDivBusy(MulDivBusy), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining mult/div stall cycles after the start cycle,
    // a pending-result flag, and a saturating stall counter.
    int m_rem  = 0;
    bit m_done = 1'b0;
    int m_sc   = 0;
    bit last_pc, last_hilo, last_idexb, last_flush;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem = 0; m_done = 1'b0; m_sc = 0;
    endtask

    task automatic zero_inputs();
        IDRs = '0; IDRt = '0; IDUsesRt = 0; EXMemRead = 0; EXDestReg = '0;
        MulDivStart = 0; MulDivIsDiv = 0; BranchTaken = 0;
    endtask

    // Called just after a falling edge with inputs applied: checks every
    // output against the model, then advances one clock.
    task automatic step();
        bit md, lu, e_pc, e_ifid, e_idex, e_idexb, e_exb, e_fl;
        #1;
        md = !m_done && (m_rem > 0 || MulDivStart);
        lu = EXMemRead && EXDestReg != 0 &&
             (EXDestReg == IDRs || (IDUsesRt && EXDestReg == IDRt));
        e_pc    = !(md || lu);
        e_ifid  = e_pc;
        e_idex  = !md;
        e_exb   = md;
        e_idexb = !md && lu;
        e_fl    = !md && !lu && BranchTaken;
        chk("PCWrite",     PCWrite,     e_pc);
        chk("IFIDWrite",   IFIDWrite,   e_ifid);
        chk("IDEXWrite",   IDEXWrite,   e_idex);
        chk("IDEXBubble",  IDEXBubble,  e_idexb);
        chk("EXMEMBubble", EXMEMBubble, e_exb);
        chk("IFIDFlush",   IFIDFlush,   e_fl);
        chk("HiLoWrite",   HiLoWrite,   m_done);
        chk("MulDivBusy",  MulDivBusy,  (m_done || m_rem > 0));
        chk("StallCount",  StallCount,  m_sc);
        last_pc = PCWrite; last_hilo = HiLoWrite;
        last_idexb = IDEXBubble; last_flush = IFIDFlush;
        @(posedge Clk);
        if (!e_pc && m_sc < 65535) m_sc++;
        if (m_done) m_done = 1'b0;
        else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (MulDivStart) m_rem = (MulDivIsDiv ? DIV : MUL) - 1;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        zero_inputs();
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_StallCount", StallCount, 0);
        chk("rst_HiLoWrite",  HiLoWrite,  0);
        chk("rst_MulDivBusy", MulDivBusy, 0);
        chk("rst_PCWrite",    PCWrite,    1);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [4:0] rs, rt, dest;
        logic       usesrt, memrd, br;
        logic       pc, ifid, idex, idexb, exb, fl;
    } vec_t;

    vec_t vecs[8];
    int   pcz, hcyc, anyb, anyf;

    initial begin
        vecs[0] = '{5'd8,  5'd0, 5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{5'd1,  5'd9, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd1,  5'd9, 5'd9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd8,  5'd0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{5'd3,  5'd4, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{5'd31, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        @(negedge Clk);
        do_reset();

        // Single-cycle hazard vectors from the sequencer's IDLE state.
        for (int i = 0; i < 8; i++) begin
            IDRs = vecs[i].rs; IDRt = vecs[i].rt; EXDestReg = vecs[i].dest;
            IDUsesRt = vecs[i].usesrt; EXMemRead = vecs[i].memrd; BranchTaken = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_PCWrite", i),     PCWrite,     vecs[i].pc);
            chk($sformatf("vec%0d_IFIDWrite", i),   IFIDWrite,   vecs[i].ifid);
            chk($sformatf("vec%0d_IDEXWrite", i),   IDEXWrite,   vecs[i].idex);
            chk($sformatf("vec%0d_IDEXBubble", i),  IDEXBubble,  vecs[i].idexb);
            chk($sformatf("vec%0d_EXMEMBubble", i), EXMEMBubble, vecs[i].exb);
            chk($sformatf("vec%0d_IFIDFlush", i),   IFIDFlush,   vecs[i].fl);
            step();
            if (i == 0) chk("loaduse_StallCount", StallCount, 1);
        end

        // Multiply: 4 stalled cycles, HI/LO strobe in cycle 5.
        do_reset();
        pcz = 0; hcyc = 0;
        for (int c = 1; c <= 7; c++) begin
            MulDivStart = (c == 1);
            step();
            if (!last_pc) pcz++;
            if (last_hilo) hcyc = c;
        end
        chk("mul_stall_cycles", pcz, MUL);
        chk("mul_hilo_cycle", hcyc, MUL + 1);
        chk("mul_StallCount", StallCount, MUL);

        // Divide with concurrent load-use, taken branch and held start.
        do_reset();
        pcz = 0; hcyc = 0; anyb = 0; anyf = 0;
        MulDivIsDiv = 1; EXMemRead = 1; EXDestReg = 5'd8; IDRs = 5'd8; BranchTaken = 1;
        for (int c = 1; c <= DIV + 3; c++) begin
            MulDivStart = (c <= DIV + 1);
            if (c == DIV + 2) begin
                EXMemRead = 0; BranchTaken = 0;
            end
            step();
            if (c <= DIV) begin
                if (!last_pc) pcz++;
                if (last_idexb) anyb++;
                if (last_flush) anyf++;
            end
            if (last_hilo && hcyc == 0) hcyc = c;
        end
        chk("div_stall_cycles", pcz, DIV);
        chk("div_idexbubble_cycles", anyb, 0);
        chk("div_flush_cycles", anyf, 0);
        chk("div_hilo_cycle", hcyc, DIV + 1);

        // Reset during divide BUSY cycle 10 abandons the operation.
        do_reset();
        MulDivIsDiv = 1;
        for (int c = 1; c <= 10; c++) begin
            MulDivStart = (c == 1);
            step();
        end
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_MulDivBusy", MulDivBusy, 0);
        chk("midrst_HiLoWrite",  HiLoWrite,  0);
        chk("midrst_StallCount", StallCount, 0);
        chk("midrst_PCWrite",    PCWrite,    1);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        hcyc = 0;
        for (int c = 0; c < DIV + 8; c++) begin
            step();
            if (last_hilo) hcyc++;
        end
        chk("midrst_hilo_after_release", hcyc, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            IDRs = 5'($urandom_range(0, 3));
            IDRt = 5'($urandom_range(0, 3));
            EXDestReg = 5'($urandom_range(0, 3));
            IDUsesRt = 1'($urandom_range(0, 1));
            EXMemRead = 1'($urandom_range(0, 1));
            BranchTaken = 1'($urandom_range(0, 1));
            MulDivStart = ($urandom_range(0, 5) == 0);
            MulDivIsDiv = 1'($urandom_range(0, 1));
            step();
        end

        // Long load-use stall saturates the counter.
        do_reset();
        EXMemRead = 1; EXDestReg = 5'd8; IDRs = 5'd8;
        for (int c = 0; c < 70000; c++) @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("sat_StallCount", StallCount, 16'hFFFF);
        m_sc = 65535;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
